// File: rtl/i2c_arb.sv
// i2c_arb: round-robin arbiter and sequencer in front of the single i2c_ctrl.
// Accepts one 16-bit register word per transaction, keeps the controller
// enabled while it runs, detects completion on the 100 kHz strobe, aborts
// on a watchdog timeout and holds enable low for a fixed gap afterwards.
module i2c_arb #(
  parameter int NREQ            = 3,
  parameter int GAP_STROBES     = 2,
  parameter int TIMEOUT_STROBES = 1000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      strobe_100kHz,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*7-1:0]         req_slave,
  input  logic [NREQ*16-1:0]        req_word,
  output logic [NREQ-1:0]           req_ready,
  output logic [NREQ-1:0]           req_done,
  output logic [NREQ-1:0]           req_err,
  output logic                      ctl_enable,
  output logic [6:0]                ctl_slave,
  output logic [15:0]               ctl_word,
  input  logic                      ctl_done,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   grant_id
);

  localparam int IDW = $clog2(NREQ);

  localparam logic [IDW-1:0] ID_ZERO  = {IDW{1'b0}};
  localparam logic [IDW-1:0] ID_ONE   = IDW'(1);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(NREQ - 1);
  localparam logic [15:0]    TO_LAST  = 16'(TIMEOUT_STROBES - 1);
  localparam logic [3:0]     GAP_LAST = 4'(GAP_STROBES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // One-hot vector with only the bit of requester `id` set.
  function automatic logic [NREQ-1:0] id_onehot(input logic [IDW-1:0] id);
    logic [NREQ-1:0] vec;
    vec = {NREQ{1'b0}};
    for (int j = 0; j < NREQ; j++) begin
      if (id == IDW'(j)) begin
        vec[j] = 1'b1;
      end else begin
        vec[j] = 1'b0;
      end
    end
    return vec;
  endfunction

  // Modulo-NREQ increment of a requester index.
  function automatic logic [IDW-1:0] id_next(input logic [IDW-1:0] id);
    logic [IDW-1:0] nxt;
    if (id == ID_LAST) begin
      nxt = ID_ZERO;
    end else begin
      nxt = id + ID_ONE;
    end
    return nxt;
  endfunction

  // Registered state
  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [15:0]     tcnt_q, tcnt_d;
  logic [3:0]      gcnt_q, gcnt_d;
  logic            ctl_enable_q, ctl_enable_d;
  logic [6:0]      ctl_slave_q, ctl_slave_d;
  logic [15:0]     ctl_word_q, ctl_word_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  logic [NREQ-1:0] req_done_q, req_done_d;
  logic [NREQ-1:0] req_err_q, req_err_d;
  logic            busy_q, busy_d;

  // Arbitration results
  logic            pick_found;
  logic [IDW-1:0]  pick_idx;
  logic [IDW-1:0]  scan_idx;
  logic [6:0]      pick_slave;
  logic [15:0]     pick_word;

  // Round-robin scan: first valid requester starting at ptr, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ID_ZERO;
    scan_idx   = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (!pick_found && req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end else begin
        pick_found = pick_found;
      end
      scan_idx = id_next(scan_idx);
    end
  end

  // Payload mux for the winning requester.
  always_comb begin
    pick_slave = 7'h00;
    pick_word  = 16'h0000;
    for (int j = 0; j < NREQ; j++) begin
      if (pick_idx == IDW'(j)) begin
        pick_slave = req_slave[j*7 +: 7];
        pick_word  = req_word[j*16 +: 16];
      end else begin
        pick_slave = pick_slave;
      end
    end
  end

  // Accept pulse: combinational, only in IDLE and never while reset is held.
  always_comb begin
    if ((state_q == ST_IDLE) && pick_found && !reset) begin
      req_ready = id_onehot(pick_idx);
    end else begin
      req_ready = {NREQ{1'b0}};
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    tcnt_d       = tcnt_q;
    gcnt_d       = gcnt_q;
    ctl_enable_d = ctl_enable_q;
    ctl_slave_d  = ctl_slave_q;
    ctl_word_d   = ctl_word_q;
    grant_id_d   = grant_id_q;
    req_done_d   = {NREQ{1'b0}};
    req_err_d    = {NREQ{1'b0}};
    busy_d       = busy_q;

    case (state_q)
      ST_IDLE: begin
        ctl_enable_d = 1'b0;
        busy_d       = 1'b0;
        if (pick_found) begin
          state_d      = ST_RUN;
          ptr_d        = id_next(pick_idx);
          grant_id_d   = pick_idx;
          ctl_slave_d  = pick_slave;
          ctl_word_d   = pick_word;
          tcnt_d       = 16'h0000;
          ctl_enable_d = 1'b1;
          busy_d       = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        ctl_enable_d = 1'b1;
        busy_d       = 1'b1;
        if (strobe_100kHz) begin
          // Done has priority over the watchdog on the same strobe.
          if (ctl_done) begin
            req_done_d   = id_onehot(grant_id_q);
            state_d      = ST_GAP;
            gcnt_d       = 4'h0;
            ctl_enable_d = 1'b0;
          end else if (tcnt_q == TO_LAST) begin
            req_err_d    = id_onehot(grant_id_q);
            state_d      = ST_GAP;
            gcnt_d       = 4'h0;
            ctl_enable_d = 1'b0;
          end else begin
            tcnt_d = tcnt_q + 16'h0001;
          end
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_GAP: begin
        ctl_enable_d = 1'b0;
        busy_d       = 1'b1;
        if (strobe_100kHz) begin
          if (gcnt_q == GAP_LAST) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            gcnt_d = gcnt_q + 4'h1;
          end
        end else begin
          state_d = ST_GAP;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        ctl_enable_d = 1'b0;
        busy_d       = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= ID_ZERO;
      tcnt_q       <= 16'h0000;
      gcnt_q       <= 4'h0;
      ctl_enable_q <= 1'b0;
      ctl_slave_q  <= 7'h00;
      ctl_word_q   <= 16'h0000;
      grant_id_q   <= ID_ZERO;
      req_done_q   <= {NREQ{1'b0}};
      req_err_q    <= {NREQ{1'b0}};
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      tcnt_q       <= tcnt_d;
      gcnt_q       <= gcnt_d;
      ctl_enable_q <= ctl_enable_d;
      ctl_slave_q  <= ctl_slave_d;
      ctl_word_q   <= ctl_word_d;
      grant_id_q   <= grant_id_d;
      req_done_q   <= req_done_d;
      req_err_q    <= req_err_d;
      busy_q       <= busy_d;
    end
  end

  assign req_done   = req_done_q;
  assign req_err    = req_err_q;
  assign ctl_enable = ctl_enable_q;
  assign ctl_slave  = ctl_slave_q;
  assign ctl_word   = ctl_word_q;
  assign busy       = busy_q;
  assign grant_id   = grant_id_q;

endmodule
